// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-number RNG stream scheduler.
package sc_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } sched_state_e;

endpackage

// File: rtl/sc_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting client strictly after ptr,
// wrapping around so that ptr itself has the lowest priority.
module sc_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [ID_W-1:0] cand;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/sc_rng_stream_scheduler.sv
// Shares one parallel LFSR among NUM_REQ SNG clients: round-robin grant, reseed,
// then ceil(len/LANES) enabled beats with a partial-lane mask on the last one.
module sc_rng_stream_scheduler
    import sc_pkg::*;
#(
    parameter  int                  NUM_REQ      = 4,
    parameter  int                  LANES        = 8,
    parameter  int                  LEN_W        = 16,
    parameter  logic [LFSR_W-1:0]   SEED_DEFAULT = sc_pkg::SEED_DEFAULT,
    localparam int                  ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*LFSR_W-1:0] req_seed,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      stall,
    input  logic                      abort,
    output logic                      rng_load,
    output logic [LFSR_W-1:0]         rng_seed,
    output logic                      rng_en,
    output logic                      beat_valid,
    output logic                      beat_last,
    output logic [LANES-1:0]          beat_mask,
    output logic [ID_W-1:0]           grant_id,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy
);

    // LANES is a power of two, so beat arithmetic reduces to shifts and low bits.
    localparam int LANE_SH = $clog2(LANES);

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     ptr_q, id_q, arb_idx;
    logic [NUM_REQ-1:0]  arb_grant;
    logic                arb_found;
    logic                handshake, beat_fire, cancel;
    logic [LFSR_W-1:0]   seed_q, seed_sel;
    logic [LEN_W-1:0]    len_sel, beats_calc, beats_q;
    logic [LANE_SH-1:0]  rem_q;
    logic [LANES-1:0]    last_mask;

    sc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .found (arb_found)
    );

    assign len_sel    = req_len[arb_idx*LEN_W +: LEN_W];
    assign seed_sel   = req_seed[arb_idx*LFSR_W +: LFSR_W];
    // Shift-plus-carry form never exceeds LEN_W bits, even for len = 2^LEN_W-1.
    assign beats_calc = (len_sel >> LANE_SH) + LEN_W'(|len_sel[LANE_SH-1:0]);

    assign handshake  = (state_q == IDLE) && arb_found;
    assign beat_fire  = (state_q == RUN) && !abort && !stall;
    assign cancel     = abort && ((state_q == LOAD) || (state_q == RUN));

    assign rng_seed   = seed_q;
    assign grant_id   = id_q;
    assign busy       = (state_q != IDLE);

    // A zero remainder means the last beat is completely full.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            last_mask[i] = (rem_q == '0) || (i < int'(rem_q));
        end
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        rng_load   = 1'b0;
        rng_en     = 1'b0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_mask  = '0;
        done       = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = arb_grant;
                if (arb_found) begin
                    state_d = (len_sel == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                rng_load = 1'b1;
                state_d  = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    rng_en     = 1'b1;
                    beat_valid = 1'b1;
                    if (beats_q == LEN_W'(1)) begin
                        beat_last = 1'b1;
                        beat_mask = last_mask;
                        state_d   = DONE;
                    end else begin
                        beat_mask = '1;
                    end
                end
            end
            DONE: begin
                done    = NUM_REQ'(1) << id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            seed_q  <= SEED_DEFAULT;
            beats_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                id_q    <= arb_idx;
                seed_q  <= (seed_sel == '0) ? SEED_DEFAULT : seed_sel;
                beats_q <= beats_calc;
                rem_q   <= len_sel[LANE_SH-1:0];
            end
            if (beat_fire) begin
                beats_q <= beats_q - LEN_W'(1);
            end
            if ((state_q == DONE) || cancel) begin
                ptr_q <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_sc_rng_stream_scheduler.sv
// Directed and randomized bench for sc_rng_stream_scheduler against a
// transaction-level model of grant order, beat count, masks and latency.
`timescale 1ns/1ps
module tb_sc_rng_stream_scheduler;

    localparam int NUM_REQ = 4;
    localparam int LANES   = 8;
    localparam int LEN_W   = 16;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*8-1:0]      req_seed;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      stall, abort;
    logic                      rng_load, rng_en, beat_valid, beat_last, busy;
    logic [7:0]                rng_seed;
    logic [LANES-1:0]          beat_mask;
    logic [1:0]                grant_id;
    logic [NUM_REQ-1:0]        done;

    int         n_cmp = 0;
    int         n_err = 0;
    int         m_ptr;
    int         lens [NUM_REQ];
    logic [7:0] seeds [NUM_REQ];

    always #5 clk = ~clk;

    sc_rng_stream_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_len    (req_len),
        .req_seed   (req_seed),
        .req_ready  (req_ready),
        .stall      (stall),
        .abort      (abort),
        .rng_load   (rng_load),
        .rng_seed   (rng_seed),
        .rng_en     (rng_en),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .beat_mask  (beat_mask),
        .grant_id   (grant_id),
        .done       (done),
        .busy       (busy)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 5 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_len[i*LEN_W +: LEN_W] = lens[i][LEN_W-1:0];
            req_seed[i*8 +: 8]        = seeds[i];
        end
    endtask

    // Model: first valid client strictly after the last served one.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(m_ptr + i) % NUM_REQ]) return (m_ptr + i) % NUM_REQ;
        end
        return 0;
    endfunction

    function automatic logic [7:0] exp_mask(input int len, input int nb, input int beats);
        int rem;
        if (nb != beats - 1) return 8'hFF;
        rem = len - (beats - 1) * LANES;
        return 8'((1 << rem) - 1);
    endfunction

    // One stream from the handshake cycle until the following IDLE cycle.
    // abort_at: 0 aborts in LOAD, k>0 aborts on the cycle of beat k, -1 never.
    task automatic do_stream(input logic [NUM_REQ-1:0] valid, input bit hold,
                             input int stall_pct, input logic [31:0] stall_plan,
                             input int abort_at, input string tag);
        int id, len, beats, nb, rc;
        logic [7:0] seed_exp;
        bit stl, abt;
        apply_cfg();
        id       = model_pick(valid);
        len      = lens[id];
        beats    = (len + LANES - 1) / LANES;
        seed_exp = (seeds[id] == 8'h00) ? 8'h01 : seeds[id];
        req_valid = valid;
        #1;
        check({tag, ":ready"}, 32'(req_ready), 32'(1) << id);
        check({tag, ":idle_busy"}, 32'(busy), 32'(0));
        step();
        if (!hold) req_valid = '0;
        #1;
        if (len != 0) begin
            check({tag, ":load"}, 32'(rng_load), 32'(1));
            check({tag, ":seed"}, 32'(rng_seed), 32'(seed_exp));
            check({tag, ":load_ready"}, 32'(req_ready), 32'(0));
            check({tag, ":load_en"}, 32'(rng_en), 32'(0));
            if (abort_at == 0) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                #1;
                check({tag, ":abort_idle"}, 32'(busy), 32'(0));
                check({tag, ":abort_nodone"}, 32'(done), 32'(0));
                m_ptr = id;
                return;
            end
            nb = 0;
            rc = 0;
            while (nb < beats) begin
                step();
                stl   = ((rc < 32) && stall_plan[rc]) || ($urandom_range(99) < stall_pct);
                abt   = (abort_at == nb + 1);
                stall = stl;
                abort = abt;
                #1;
                if (abt) begin
                    step();
                    stall = 1'b0;
                    abort = 1'b0;
                    #1;
                    check({tag, ":abort_idle"}, 32'(busy), 32'(0));
                    check({tag, ":abort_nodone"}, 32'(done), 32'(0));
                    m_ptr = id;
                    return;
                end
                if (stl) begin
                    check({tag, ":stall_en"}, 32'(rng_en), 32'(0));
                    check({tag, ":stall_valid"}, 32'(beat_valid), 32'(0));
                end else begin
                    check({tag, ":beat_en"}, 32'(rng_en), 32'(1));
                    check({tag, ":beat_valid"}, 32'(beat_valid), 32'(1));
                    check({tag, ":beat_last"}, 32'(beat_last), 32'(nb == beats - 1));
                    check({tag, ":beat_mask"}, 32'(beat_mask), 32'(exp_mask(len, nb, beats)));
                    check({tag, ":grant_id"}, 32'(grant_id), 32'(id));
                    nb++;
                end
                rc++;
            end
            stall = 1'b0;
            step();
            #1;
        end
        check({tag, ":done"}, 32'(done), 32'(1) << id);
        check({tag, ":done_load"}, 32'(rng_load), 32'(0));
        check({tag, ":done_valid"}, 32'(beat_valid), 32'(0));
        check({tag, ":done_ready"}, 32'(req_ready), 32'(0));
        m_ptr = id;
        step();
        #1;
        check({tag, ":after_done"}, 32'(done), 32'(0));
        check({tag, ":after_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int al;
        reset     = 1'b1;
        req_valid = '0;
        req_len   = '0;
        req_seed  = '0;
        stall     = 1'b0;
        abort     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            lens[i]  = 8;
            seeds[i] = 8'h33;
        end
        m_ptr = NUM_REQ - 1;
        #3;
        check("rst:busy", 32'(busy), 32'(0));
        check("rst:ready", 32'(req_ready), 32'(0));
        check("rst:load", 32'(rng_load), 32'(0));
        check("rst:en", 32'(rng_en), 32'(0));
        check("rst:done", 32'(done), 32'(0));
        check("rst:grant_id", 32'(grant_id), 32'(0));
        check("rst:seed", 32'(rng_seed), 32'(8'h01));
        #9;
        reset = 1'b0;

        lens[0] = 16;  seeds[0] = 8'h5A;
        do_stream(4'b0001, 1'b0, 0, 32'h0, -1, "t1");
        lens[1] = 13;
        do_stream(4'b0010, 1'b0, 0, 32'h0, -1, "t2");
        lens[3] = 8;
        do_stream(4'b1000, 1'b0, 0, 32'h0, -1, "t3_prep");

        for (int i = 0; i < NUM_REQ; i++) lens[i] = 8;
        for (int k = 0; k < 5; k++) do_stream(4'b1111, 1'b1, 0, 32'h0, -1, "t3_rr");
        req_valid = '0;

        lens[1] = 24;
        do_stream(4'b0010, 1'b0, 0, 32'h6, -1, "t4_stall");
        lens[2] = 8;   seeds[2] = 8'h00;
        do_stream(4'b0100, 1'b0, 0, 32'h0, -1, "t5_zero_seed");
        lens[3] = 0;
        do_stream(4'b1000, 1'b0, 0, 32'h0, -1, "t6_len0");
        lens[0] = 65535;
        do_stream(4'b0001, 1'b0, 0, 32'h0, -1, "len_max");
        lens[1] = 1;
        do_stream(4'b0010, 1'b0, 0, 32'h0, -1, "len1");

        for (int i = 0; i < NUM_REQ; i++) lens[i] = 32;
        do_stream(4'b0100, 1'b0, 0, 32'h0, 2, "t7_abort");
        do_stream(4'b1111, 1'b0, 0, 32'h0, -1, "t7_next");

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ($urandom_range(5))
                    0:       lens[i] = 0;
                    1:       lens[i] = 1;
                    2:       lens[i] = 8;
                    3:       lens[i] = 9;
                    default: lens[i] = $urandom_range(100, 1);
                endcase
                seeds[i] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255));
            end
            al = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1;
            do_stream(4'($urandom_range(15, 1)), 1'b0, int'($urandom_range(40)), 32'h0, al, "rand");
        end

        lens[2] = 40;
        apply_cfg();
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("t8:busy", 32'(busy), 32'(0));
        check("t8:en", 32'(rng_en), 32'(0));
        check("t8:valid", 32'(beat_valid), 32'(0));
        check("t8:mask", 32'(beat_mask), 32'(0));
        check("t8:done", 32'(done), 32'(0));
        check("t8:seed", 32'(rng_seed), 32'(8'h01));
        check("t8:grant_id", 32'(grant_id), 32'(0));
        step();
        reset = 1'b0;
        m_ptr = NUM_REQ - 1;
        lens[0] = 8;
        do_stream(4'b1111, 1'b0, 0, 32'h0, -1, "t8_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
